// File: rtl/avalon_write_master.sv
// Avalon-MM write master: packs a user byte stream into 32-bit words and writes them from a base address.
// Optional feature macro WRITE_MASTER_EARLY_DONE_EN adds control_early_done.
module avalon_write_master #(
  parameter int ADDRESSWIDTH   = 32,
  parameter int FIFODEPTH      = 16,
  parameter int FIFODEPTH_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    control_fixed_location,
  input  logic [31:0]             control_write_base,
  input  logic [31:0]             control_write_length,
  input  logic                    control_go,
  output logic                    control_done,
`ifdef WRITE_MASTER_EARLY_DONE_EN
  output logic                    control_early_done,
`endif
  input  logic                    user_write_buffer,
  input  logic [7:0]              user_buffer_input_data,
  output logic                    user_buffer_full,
  output logic [ADDRESSWIDTH-1:0] master_address,
  output logic                    master_write,
  output logic [3:0]              master_byteenable,
  output logic [31:0]             master_writedata,
  input  logic                    master_waitrequest
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [FIFODEPTH_LOG2:0]   CNT_ONE  = (FIFODEPTH_LOG2+1)'(1);
  localparam logic [FIFODEPTH_LOG2:0]   CNT_FULL = (FIFODEPTH_LOG2+1)'(FIFODEPTH);
  localparam logic [FIFODEPTH_LOG2-1:0] PTR_ONE  = FIFODEPTH_LOG2'(1);

  state_t                    state_q, state_d;
  logic                      done_q, done_d;
  logic                      fixed_q, fixed_d;
  logic [31:0]               length_q, length_d;
  logic [31:0]               bytes_q, bytes_d;
  logic [1:0]                lane_q, lane_d;
  logic [23:0]               pack_q, pack_d;
  logic [ADDRESSWIDTH-1:0]   addr_q, addr_d;
  logic                      write_q, write_d;
  logic [FIFODEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFODEPTH_LOG2:0]   count_q, count_d;
  logic [35:0]               fifo_mem_q [FIFODEPTH];
`ifdef WRITE_MASTER_EARLY_DONE_EN
  logic                      early_done_q, early_done_d;
`endif

  logic        fifo_full, capture, last_byte, push, pop;
  logic [31:0] word_data;
  logic [3:0]  word_be;
  logic [35:0] head;

  assign fifo_full        = (count_q == CNT_FULL);
  assign user_buffer_full = (state_q != S_RUN) | fifo_full | (bytes_q == length_q);
  assign capture          = user_write_buffer & ~user_buffer_full;
  assign last_byte        = (bytes_q + 32'd1) == length_q;
  assign push             = capture & ((lane_q == 2'd3) | last_byte);
  assign pop              = write_q & ~master_waitrequest;

  // Little-endian lane placement of the incoming byte; unused upper lanes stay zero.
  always_comb begin
    word_data = {8'h00, pack_q};
    word_be   = 4'hF;
    case (lane_q)
      2'd0:    begin word_data[7:0]   = user_buffer_input_data; word_be = 4'h1; end
      2'd1:    begin word_data[15:8]  = user_buffer_input_data; word_be = 4'h3; end
      2'd2:    begin word_data[23:16] = user_buffer_input_data; word_be = 4'h7; end
      default: begin word_data[31:24] = user_buffer_input_data; word_be = 4'hF; end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    fixed_d  = fixed_q;
    length_d = length_q;
    bytes_d  = bytes_q;
    lane_d   = lane_q;
    pack_d   = pack_q;
    addr_d   = addr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
`ifdef WRITE_MASTER_EARLY_DONE_EN
    early_done_d = early_done_q;
`endif
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // Write is raised only from a word already sitting in the FIFO, and held while words remain.
    write_d = (count_q != '0) && (count_d != '0);
    if (pop && !fixed_q) addr_d = addr_q + ADDRESSWIDTH'(4);
    if (capture) begin
      bytes_d = bytes_q + 32'd1;
      if (push) begin
        lane_d = 2'd0;
        pack_d = '0;
      end else begin
        lane_d = lane_q + 2'd1;
        pack_d = word_data[23:0];
      end
    end
    case (state_q)
      S_IDLE: begin
        if (control_go) begin
          fixed_d  = control_fixed_location;
          length_d = control_write_length;
          bytes_d  = '0;
          lane_d   = 2'd0;
          pack_d   = '0;
          addr_d   = ADDRESSWIDTH'(control_write_base & 32'hFFFF_FFFC);
          done_d   = 1'b0;
          state_d  = (control_write_length == 32'd0) ? S_DRAIN : S_RUN;
`ifdef WRITE_MASTER_EARLY_DONE_EN
          early_done_d = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (capture && last_byte) begin
          state_d = S_DRAIN;
`ifdef WRITE_MASTER_EARLY_DONE_EN
          early_done_d = 1'b1;
`endif
        end
      end
      default: begin
        if (count_q == '0 && !write_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
`ifdef WRITE_MASTER_EARLY_DONE_EN
          early_done_d = 1'b1;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b1;
      fixed_q  <= 1'b0;
      length_q <= '0;
      bytes_q  <= '0;
      lane_q   <= 2'd0;
      pack_q   <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef WRITE_MASTER_EARLY_DONE_EN
      early_done_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      fixed_q  <= fixed_d;
      length_q <= length_d;
      bytes_q  <= bytes_d;
      lane_q   <= lane_d;
      pack_q   <= pack_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef WRITE_MASTER_EARLY_DONE_EN
      early_done_q <= early_done_d;
`endif
    end
  end

  // Word storage carries no reset; outputs are gated by write_q so reset still reads as zero.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {word_be, word_data};
  end

  assign head              = fifo_mem_q[rd_ptr_q];
  assign control_done      = done_q;
  assign master_address    = addr_q;
  assign master_write      = write_q;
  assign master_writedata  = write_q ? head[31:0]  : 32'h0;
  assign master_byteenable = write_q ? head[35:32] : 4'h0;
`ifdef WRITE_MASTER_EARLY_DONE_EN
  assign control_early_done = early_done_q;
`endif

endmodule

// File: tb/tb_avalon_write_master.sv
// Scoreboard bench for avalon_write_master: a byte-level model predicts every Avalon write.
module tb_avalon_write_master;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        control_fixed_location = 1'b0;
  logic [31:0] control_write_base = '0;
  logic [31:0] control_write_length = '0;
  logic        control_go = 1'b0;
  logic        control_done;
  logic        user_write_buffer = 1'b0;
  logic [7:0]  user_buffer_input_data = '0;
  logic        user_buffer_full;
  logic [31:0] master_address;
  logic        master_write;
  logic [3:0]  master_byteenable;
  logic [31:0] master_writedata;
  logic        master_waitrequest;
`ifdef WRITE_MASTER_EARLY_DONE_EN
  logic        control_early_done;
`endif

  always #5 clk = ~clk;

  avalon_write_master dut (
    .clk(clk), .reset_n(reset_n),
    .control_fixed_location(control_fixed_location),
    .control_write_base(control_write_base),
    .control_write_length(control_write_length),
    .control_go(control_go), .control_done(control_done),
`ifdef WRITE_MASTER_EARLY_DONE_EN
    .control_early_done(control_early_done),
`endif
    .user_write_buffer(user_write_buffer),
    .user_buffer_input_data(user_buffer_input_data),
    .user_buffer_full(user_buffer_full),
    .master_address(master_address), .master_write(master_write),
    .master_byteenable(master_byteenable), .master_writedata(master_writedata),
    .master_waitrequest(master_waitrequest)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] be; } wr_t;
  wr_t        exp_q[$];
  logic [7:0] bytes_arr [0:255];
  int n_checks = 0, n_fail = 0, n_accept = 0, last_accept_edge = 0;
  int cyc = 0, wmode = 0, stall_left = 0, first_full = -1;
  bit abort = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m = '0;
    for (int k = 0; k < 4; k++) if (be[k]) m[8*k +: 8] = 8'hFF;
    return m;
  endfunction

  // Expected writes: one per group of up to four bytes, lanes filled from byte 0 upward.
  task automatic model(input logic [31:0] base, input int len, input bit fixed);
    logic [31:0] a0 = base & 32'hFFFF_FFFC;
    for (int w = 0; w * 4 < len; w++) begin
      wr_t t;
      t.addr = fixed ? a0 : a0 + 32'(4 * w);
      t.data = '0;
      t.be   = '0;
      for (int k = 0; k < 4; k++)
        if (w * 4 + k < len) begin
          t.data[8*k +: 8] = bytes_arr[w*4+k];
          t.be[k] = 1'b1;
        end
      exp_q.push_back(t);
    end
  endtask

  initial begin
    master_waitrequest = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (wmode)
        0: master_waitrequest = 1'b0;
        1: master_waitrequest = ($urandom_range(0, 2) == 0);
        2: master_waitrequest = 1'b1;
        default: begin
          if (stall_left > 0 && master_write) begin
            master_waitrequest = 1'b1;
            stall_left--;
          end else master_waitrequest = 1'b0;
        end
      endcase
    end
  end

  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr, prev_data;
  logic [3:0]  prev_be;
  always @(negedge clk) begin
    if (!reset_n) prev_wait = 1'b0;
    else begin
      if (prev_wait) begin
        chk("stall_write", master_write, 1);
        chk("stall_addr", master_address, prev_addr);
        chk("stall_data", master_writedata, prev_data);
        chk("stall_be", master_byteenable, prev_be);
      end
      if (master_write && !master_waitrequest) begin
        n_accept++;
        last_accept_edge = cyc + 1;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h be %0h, none expected",
                   master_address, master_writedata, master_byteenable);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", master_address, e.addr);
          chk("wr_data", master_writedata & be_mask(e.be), e.data);
          chk("wr_be", master_byteenable, e.be);
        end
      end
      prev_wait = master_write && master_waitrequest;
      prev_addr = master_address;
      prev_data = master_writedata;
      prev_be   = master_byteenable;
    end
  end

  task automatic send_bytes(input int len, input bit gaps);
    int idx = 0, guard = 0;
    while (idx < len && !abort && guard < 4000) begin
      @(posedge clk); #1;
      guard++;
      if (user_buffer_full) begin
        if (first_full < 0) first_full = idx;
        user_write_buffer      = 1'($urandom_range(0, 1));
        user_buffer_input_data = 8'($urandom);
      end else if (!gaps || $urandom_range(0, 3) != 0) begin
        user_write_buffer      = 1'b1;
        user_buffer_input_data = bytes_arr[idx];
        idx++;
      end else begin
        user_write_buffer      = 1'b0;
        user_buffer_input_data = 8'($urandom);
      end
    end
    if (idx < len && !abort) begin
      n_checks++; n_fail++;
      $display("FAIL byte_stream_timeout: sent %0d of %0d bytes", idx, len);
    end
    @(posedge clk); #1;
    user_write_buffer = 1'b0;
  endtask

  task automatic start_go(input logic [31:0] base, input int len, input bit fixed, output int c);
    @(posedge clk); #1;
    chk("idle_done", control_done, 1);
    control_write_base     = base;
    control_write_length   = 32'(len);
    control_fixed_location = fixed;
    control_go             = 1'b1;
    c = cyc;
    @(posedge clk); #1;
    control_go             = 1'b0;
    control_write_base     = $urandom;
    control_write_length   = $urandom;
    control_fixed_location = ~fixed;
    chk("go_done_low", control_done, 0);
`ifdef WRITE_MASTER_EARLY_DONE_EN
    chk("go_early_done_low", control_early_done, 0);
`endif
  endtask

  task automatic run_xfer(input logic [31:0] base, input int len, input bit fixed,
                          input int mode, input bit gaps, input bit seq, input bit glitch);
    int c, i;
    for (int j = 0; j < len; j++) bytes_arr[j] = seq ? 8'(j + 1) : 8'($urandom);
    model(base, len, fixed);
    wmode = mode; first_full = -1; stall_left = 10;
    start_go(base, len, fixed, c);
    fork
      send_bytes(len, gaps);
      begin
        if (glitch) begin
          repeat (4) @(posedge clk); #1;
          control_write_base = 32'h0000_7000;
          control_go = 1'b1;
          @(posedge clk); #1;
          control_go = 1'b0;
        end
      end
      begin
        if (mode == 2) begin
          for (int k = 0; k < 3000 && first_full < 0; k++) @(posedge clk);
          repeat (10) @(posedge clk);
          wmode = 0;
        end
      end
    join
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (control_done) break;
    end
    chk("done_returns", control_done, 1);
    if (len == 0) chk("done_zero_len_timing", cyc, c + 2);
    else chk("done_timing", cyc, last_accept_edge + 1);
`ifdef WRITE_MASTER_EARLY_DONE_EN
    chk("early_done_end", control_early_done, 1);
`endif
    chk("writes_outstanding", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int c, base_acc;
    #2 reset_n = 1'b0;
    #2;
    chk("rst_done", control_done, 1);
    chk("rst_write", master_write, 0);
    chk("rst_addr", master_address, 0);
    chk("rst_be", master_byteenable, 0);
    chk("rst_data", master_writedata, 0);
    chk("rst_full", user_buffer_full, 1);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    run_xfer(32'h1000, 8, 0, 0, 0, 1, 0);
    run_xfer(32'h1000, 5, 0, 0, 0, 1, 0);
    run_xfer(32'h1000, 8, 0, 3, 0, 0, 0);
    run_xfer(32'h3000, 80, 0, 2, 0, 0, 0);
    chk("full_after_64_bytes", first_full, 64);
    run_xfer(32'h2000, 12, 1, 0, 0, 0, 0);
    run_xfer(32'h2000, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a transfer, after three words have been accepted.
    for (int j = 0; j < 40; j++) bytes_arr[j] = 8'($urandom);
    model(32'h4000, 40, 0);
    wmode = 0;
    base_acc = n_accept;
    start_go(32'h4000, 40, 0, c);
    fork
      send_bytes(40, 0);
      begin
        for (int k = 0; k < 2000 && n_accept < base_acc + 3; k++) @(posedge clk);
        #2 reset_n = 1'b0;
        abort = 1'b1;
      end
    join
    #1;
    chk("midrst_write", master_write, 0);
    chk("midrst_done", control_done, 1);
    chk("midrst_addr", master_address, 0);
    chk("midrst_full", user_buffer_full, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    abort = 1'b0;
    run_xfer(32'h5000, 40, 0, 0, 0, 0, 1);

    for (int t = 0; t < 12; t++) begin
      logic [31:0] b;
      b = (t % 4 == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      run_xfer(b, $urandom_range(0, 40), 1'($urandom_range(0, 1)), 1, 1, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
